// File: rtl/gpio_in_events_if.sv
// Peripheral bus for gpio_in_events: address, write data/strobe, read strobe and
// combinational read data.
interface gpio_in_events_if;
    logic [3:0]  a;
    logic [31:0] d;
    logic        we;
    logic        re;
    logic [31:0] spo;

    modport master (output a, output d, output we, output re, input spo);
    modport slave  (input a, input d, input we, input re, output spo);
endinterface

// File: rtl/gpio_in_events.sv
// Synchronised, debounced GPIO inputs with a change-event FIFO and level interrupt.
// Optional macro GPIO_IN_TIMESTAMP_EN adds a 15-bit tick timestamp to each event.
module gpio_in_events #(
    parameter int N_IN        = 4,
    parameter int DEPTH_LOG2  = 3,
    parameter int PRESCALE    = 1000,
    parameter int DEB_DEFAULT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    gpio_in_events_if.slave      bus,
    input  logic [N_IN-1:0]      pins,
    output logic                 irq
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW    = (N_IN > 1) ? $clog2(N_IN) : 1;

    logic [N_IN-1:0]       sync1_r, sync2_r, q_r, mask_r, ready_s;
    logic [7:0]            cnt_r [N_IN];
    logic [7:0]            thr_r, thr_eff_s;
    logic [PW-1:0]         presc_r;
    logic                  tick_s;
    logic                  commit_s;
    logic [3:0]            commit_idx_s;
    logic [IW-1:0]         commit_sel_s;
    logic [31:0]           mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_r, rd_ptr_r;
    logic [DEPTH_LOG2:0]   count_r;
    logic                  ovf_r, irq_r;
    logic                  empty_s, full_s, pop_s, push_req_s, push_s, ovf_set_s;
    logic [14:0]           ts_s;
    logic [31:0]           event_s, stat_s;

    // Two-stage synchroniser and debounce prescaler.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_r <= '0;
            sync2_r <= '0;
            presc_r <= '0;
        end else begin
            sync1_r <= pins;
            sync2_r <= sync1_r;
            presc_r <= tick_s ? '0 : presc_r + 1'b1;
        end
    end

    assign tick_s    = (presc_r == PW'(PRESCALE - 1));
    assign thr_eff_s = (thr_r == 8'd0) ? 8'd1 : thr_r;

    // Ready lines and lowest-index commit selection; others wait at threshold.
    always_comb begin
        commit_idx_s = 4'd0;
        for (int i = 0; i < N_IN; i++) begin
            ready_s[i] = (sync2_r[i] != q_r[i]) && (cnt_r[i] >= thr_eff_s);
        end
        for (int i = N_IN - 1; i >= 0; i--) begin
            commit_idx_s = ready_s[i] ? 4'(i) : commit_idx_s;
        end
        commit_s = |ready_s;
    end

    assign commit_sel_s = commit_idx_s[IW-1:0];

    // Per-input debounce counters and debounced levels.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q_r <= '0;
            for (int i = 0; i < N_IN; i++) cnt_r[i] <= 8'd0;
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (sync2_r[i] == q_r[i])                                cnt_r[i] <= 8'd0;
                else if (commit_s && (commit_idx_s == 4'(i)))            cnt_r[i] <= 8'd0;
                else if (tick_s && (cnt_r[i] < thr_eff_s))               cnt_r[i] <= cnt_r[i] + 8'd1;
                else                                                     cnt_r[i] <= cnt_r[i];
            end
            if (commit_s) q_r[commit_sel_s] <= sync2_r[commit_sel_s];
        end
    end

`ifdef GPIO_IN_TIMESTAMP_EN
    logic [14:0] ts_r;

    // Free-running tick timestamp, wraps at 0x7FFF.
    always_ff @(posedge clk) begin
        if (!rst)        ts_r <= 15'd0;
        else if (tick_s) ts_r <= ts_r + 15'd1;
        else             ts_r <= ts_r;
    end
    assign ts_s = ts_r;
`else
    assign ts_s = 15'd0;
`endif

    assign empty_s    = (count_r == '0);
    assign full_s     = (count_r == (DEPTH_LOG2+1)'(DEPTH));
    assign pop_s      = bus.re && (bus.a == 4'd1) && !empty_s;
    assign push_req_s = commit_s && mask_r[commit_sel_s];
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push_s     = push_req_s && (!full_s || pop_s);
    assign ovf_set_s  = push_req_s && full_s && !pop_s;
    assign event_s    = {1'b1, ts_s, 7'd0, sync2_r[commit_sel_s], 4'd0, commit_idx_s};

    // Event storage array (no reset needed; guarded by count).
    always_ff @(posedge clk) begin
        if (push_s) mem_r[wr_ptr_r] <= event_s;
    end

    // FIFO pointers, occupancy, overflow, config registers and interrupt.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            ovf_r    <= 1'b0;
            mask_r   <= '1;
            thr_r    <= 8'(DEB_DEFAULT);
            irq_r    <= 1'b0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
            if (ovf_set_s)                                  ovf_r <= 1'b1;
            else if (bus.we && (bus.a == 4'd4) && bus.d[0]) ovf_r <= 1'b0;
            else                                            ovf_r <= ovf_r;
            if (bus.we && (bus.a == 4'd3)) mask_r <= bus.d[N_IN-1:0];
            if (bus.we && (bus.a == 4'd5)) thr_r  <= bus.d[7:0];
            irq_r <= !empty_s;
        end
    end

    assign irq = irq_r;

    // Status word and read-data multiplexer.
    always_comb begin
        stat_s      = 32'd0;
        stat_s[16]  = ovf_r;
        stat_s[9]   = full_s;
        stat_s[8]   = empty_s;
        stat_s[4:0] = 5'(count_r);
        case (bus.a)
            4'd0:    bus.spo = 32'(q_r);
            4'd1:    bus.spo = empty_s ? 32'd0 : mem_r[rd_ptr_r];
            4'd2:    bus.spo = stat_s;
            4'd3:    bus.spo = 32'(mask_r);
            4'd5:    bus.spo = 32'(thr_r);
            default: bus.spo = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_gpio_in_events.sv
// Bench for gpio_in_events: register table, directed event sequences and random
// traffic, all compared each cycle against a queue-based reference model.
module tb_gpio_in_events;
    localparam int PRE = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] pins = 4'h0;
    logic       irq;
    int         n_chk = 0;
    int         n_err = 0;

    gpio_in_events_if bus ();

    gpio_in_events #(.N_IN(4), .DEPTH_LOG2(3), .PRESCALE(PRE), .DEB_DEFAULT(8)) dut (
        .clk(clk), .rst(rst), .bus(bus), .pins(pins), .irq(irq)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int          m_cnt [4];
    bit [3:0]    m_q, m_mask;
    bit [7:0]    m_thr;
    bit          m_ovf, m_irq;
    int          m_cyc, m_ticks;
    bit [31:0]   m_fifo [$];
    bit [3:0]    m_hist [$];

    function automatic bit [31:0] m_read(input bit [3:0] a);
        case (a)
            4'd0: return {28'd0, m_q};
            4'd1: return (m_fifo.size() > 0) ? m_fifo[0] : 32'd0;
            4'd2: return {15'd0, m_ovf, 6'd0, bit'(m_fifo.size() == 8),
                          bit'(m_fifo.size() == 0), 3'd0, 5'(m_fifo.size())};
            4'd3: return {28'd0, m_mask};
            4'd5: return {24'd0, m_thr};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_update();
        bit [3:0]  s;
        int        thre, ci;
        bit        tick, ovf_set, was_nonempty;
        bit [31:0] w;
        if (!rst) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_q = 4'h0; m_mask = 4'hF; m_thr = 8'd8; m_ovf = 1'b0; m_irq = 1'b0;
            m_cyc = 0; m_ticks = 0; m_fifo.delete();
            m_hist.delete(); m_hist.push_back(4'h0); m_hist.push_back(4'h0);
            return;
        end
        s    = m_hist[0];
        thre = (m_thr == 8'd0) ? 1 : int'(m_thr);
        tick = ((m_cyc % PRE) == PRE - 1);
        ci   = -1;
        for (int i = 0; i < 4; i++)
            if (ci < 0 && s[i] != m_q[i] && m_cnt[i] >= thre) ci = i;
        was_nonempty = (m_fifo.size() != 0);
        ovf_set = 1'b0;
        if (bus.re && bus.a == 4'd1 && m_fifo.size() > 0) void'(m_fifo.pop_front());
        if (ci >= 0 && m_mask[ci]) begin
            w = 32'h8000_0000 | (32'(s[ci]) << 8) | 32'(ci);
`ifdef GPIO_IN_TIMESTAMP_EN
            w = w | (32'(m_ticks % 32768) << 16);
`endif
            if (m_fifo.size() < 8) m_fifo.push_back(w);
            else ovf_set = 1'b1;
        end
        if (ovf_set) m_ovf = 1'b1;
        else if (bus.we && bus.a == 4'd4 && bus.d[0]) m_ovf = 1'b0;
        if (bus.we && bus.a == 4'd3) m_mask = bus.d[3:0];
        if (bus.we && bus.a == 4'd5) m_thr = bus.d[7:0];
        for (int i = 0; i < 4; i++) begin
            if (s[i] == m_q[i]) m_cnt[i] = 0;
            else if (i == ci) m_cnt[i] = 0;
            else if (tick && m_cnt[i] < thre) m_cnt[i]++;
        end
        if (ci >= 0) m_q[ci] = s[ci];
        m_irq = was_nonempty;
        if (tick) m_ticks++;
        m_cyc++;
        void'(m_hist.pop_front());
        m_hist.push_back(pins);
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        chk("irq_vs_model", 32'(irq), 32'(m_irq));
        chk("spo_vs_model", bus.spo, m_read(bus.a));
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) step();
    endtask

    task automatic wr(input bit [3:0] a, input bit [31:0] d);
        bus.a = a; bus.d = d; bus.we = 1'b1;
        step();
        bus.we = 1'b0;
    endtask

    task automatic rd_chk(input string name, input bit [3:0] a, input bit [31:0] exp);
        bus.a = a;
        #1;
        chk(name, bus.spo & ((a == 4'd1) ? 32'h8000_FFFF : 32'hFFFF_FFFF), exp);
    endtask

    task automatic pop_chk(input string name, input bit [31:0] exp);
        rd_chk(name, 4'd1, exp);
        bus.re = 1'b1;
        step();
        bus.re = 1'b0;
    endtask

    task automatic wait_irq(input int limit);
        int k = 0;
        while (irq !== 1'b1 && k < limit) begin step(); k++; end
        chk("irq_wait", 32'(irq), 32'd1);
    endtask

    typedef struct {
        bit        we;
        bit [3:0]  a;
        bit [31:0] d;
        bit [31:0] exp;
    } vec_t;

    vec_t vecs [13];

    initial begin
        vecs[0]  = '{1'b0, 4'd0,  32'd0,          32'h0};
        vecs[1]  = '{1'b0, 4'd1,  32'd0,          32'h0};
        vecs[2]  = '{1'b0, 4'd2,  32'd0,          32'h100};
        vecs[3]  = '{1'b0, 4'd3,  32'd0,          32'hF};
        vecs[4]  = '{1'b0, 4'd4,  32'd0,          32'h0};
        vecs[5]  = '{1'b0, 4'd5,  32'd0,          32'h8};
        vecs[6]  = '{1'b1, 4'd5,  32'h0000_0103,  32'h3};
        vecs[7]  = '{1'b1, 4'd3,  32'hFFFF_FFF5,  32'h5};
        vecs[8]  = '{1'b1, 4'd3,  32'h0000_000F,  32'hF};
        vecs[9]  = '{1'b1, 4'd4,  32'h0000_0001,  32'h0};
        vecs[10] = '{1'b1, 4'd7,  32'h0000_0055,  32'h0};
        vecs[11] = '{1'b0, 4'd15, 32'd0,          32'h0};
        vecs[12] = '{1'b1, 4'd5,  32'h0000_0000,  32'h0};

        bus.a = 4'd0; bus.d = 32'd0; bus.we = 1'b0; bus.re = 1'b0;
        rst = 1'b0;
        step(); step();
        rst = 1'b1;
        rd_chk("reset_status", 4'd2, 32'h100);
        chk("reset_irq", 32'(irq), 32'd0);

        // Register table
        for (int i = 0; i < 13; i++) begin
            bus.a = vecs[i].a; bus.d = vecs[i].d; bus.we = vecs[i].we;
            step();
            bus.we = 1'b0;
            chk($sformatf("vec%0d", i), bus.spo, vecs[i].exp);
        end

        // Single rising edge on pin0, thr=2
        wr(4'd5, 32'd2);
        bus.a = 4'd2;
        pins = 4'b0001;
        wait_irq(40);
        rd_chk("rise0_q", 4'd0, 32'h1);
        pop_chk("rise0_event", 32'h8000_0100);
        pins = 4'b0000;
        wait_cycles(20);
        pop_chk("fall0_event", 32'h8000_0000);

        // Pins 0 and 2 rise together: index 0 first, then index 2
        pins = 4'b0101;
        wait_cycles(20);
        rd_chk("two_count", 4'd2, 32'h2);
        pop_chk("two_first", 32'h8000_0100);
        pop_chk("two_second", 32'h8000_0102);
        pins = 4'b0000;
        wait_cycles(20);
        pop_chk("two_fall_first", 32'h8000_0000);
        pop_chk("two_fall_second", 32'h8000_0002);

        // Glitch shorter than threshold on pin1
        wr(4'd5, 32'd3);
        pins = 4'b0010;
        wait_cycles(PRE);
        pins = 4'b0000;
        wait_cycles(30);
        rd_chk("glitch_status", 4'd2, 32'h100);
        rd_chk("glitch_q", 4'd0, 32'h0);

        // Nine events into an 8-deep FIFO
        wr(4'd5, 32'd1);
        for (int k = 0; k < 9; k++) begin
            pins[0] = ~pins[0];
            wait_cycles(12);
        end
        rd_chk("ovf_status", 4'd2, 32'h0001_0208);
        wr(4'd4, 32'd1);
        rd_chk("ovf_clear", 4'd2, 32'h0000_0208);
        for (int k = 0; k < 8; k++)
            pop_chk($sformatf("ovf_pop%0d", k), (k % 2 == 0) ? 32'h8000_0100 : 32'h8000_0000);
        step();
        chk("ovf_irq_low", 32'(irq), 32'd0);
        rd_chk("ovf_empty", 4'd2, 32'h100);

        // Masked-out pin still updates q
        wr(4'd3, 32'hE);
        pins[0] = 1'b0;
        wait_cycles(15);
        rd_chk("mask_q", 4'd0, 32'h0);
        rd_chk("mask_status", 4'd2, 32'h100);

        // Reset with three events queued
        wr(4'd3, 32'hF);
        pins = 4'b1110;
        wait_cycles(15);
        rd_chk("pre_rst_count", 4'd2, 32'h3);
        chk("pre_rst_irq", 32'(irq), 32'd1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        rd_chk("rst_status", 4'd2, 32'h100);
        chk("rst_irq", 32'(irq), 32'd0);
        rd_chk("rst_mask", 4'd3, 32'hF);
        rd_chk("rst_thr", 4'd5, 32'h8);
        rd_chk("rst_q", 4'd0, 32'h0);
        wait_cycles(60);
        rd_chk("post_rst_q", 4'd0, 32'hE);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 24) == 0) pins[$urandom_range(0, 3)] ^= 1'b1;
            bus.a  = ($urandom_range(0, 1) == 0) ? 4'd1 : 4'($urandom_range(0, 7));
            bus.re = ($urandom_range(0, 3) == 0);
            bus.we = ($urandom_range(0, 29) == 0);
            bus.d  = 32'($urandom);
            if (bus.a == 4'd5) bus.d = 32'($urandom_range(0, 3));
            step();
            bus.we = 1'b0;
            bus.re = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/gpio_in_events.md
Name: gpio_in_events

Overview:
- Input-direction companion to the LED/switch GPIO block.
- Synchronises and debounces raw button/switch lines, then detects level changes on the debounced lines.
- Queues each change as an event word in a small FIFO, which the CPU drains through the standard peripheral bus (a/d/we/spo, plus read strobe re).
- Raises a level interrupt while unread events are pending.

Parameters:
- N_IN, 4, number of input lines (1..16); index field is 4 bits.
- DEPTH_LOG2, 3, event FIFO depth = 2**DEPTH_LOG2 (8).
- PRESCALE, 1000, clk cycles per debounce tick.
- DEB_DEFAULT, 8, reset value of debounce threshold in ticks (8-bit).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset (rst=0 resets on clk edge)
- a  in  4  register address
- d  in  32  write data
- we  in  1  write strobe, one cycle per write
- re  in  1  read strobe; asserted for exactly one cycle per CPU read, same cycle spo is sampled
- spo  out  32  read data, combinational from a and registered state
- pins  in  N_IN  raw asynchronous inputs
- irq  out  1  registered level interrupt

Behaviour:
- Sync: 2-FF synchroniser per pin; sync value s[i].
- Tick: prescaler counts 0..PRESCALE-1; tick pulses 1 cycle at wrap.
- Debounce, per input, 8-bit counter c[i], debounced level q[i]:
  - s[i]==q[i]: c[i]<=0.
  - else on tick, c[i]<=c[i]+1 if c[i]<thr.
  - c[i]>=thr → input i "ready".
  - thr==0 treated as 1.
- Commit: at most one input commits per cycle, the lowest-index ready input. On commit: q[i]<=s[i], c[i]<=0. Other ready inputs hold at threshold and commit in later cycles.
- Event push on commit only if mask[i]=1. Event word:
  - bit31=1 (valid)
  - bits30:16 timestamp (see Optional Feature)
  - bit8 new level
  - bits3:0 index
  - rest 0
- FIFO full at push: event dropped, ovf sticky <=1. q[i] still updates.
- Register map (a):
  - 0 R: {zeros, q}.
  - 1 R: FIFO head word if non-empty, else 0. re with a==1 and non-empty pops. re on empty FIFO is a no-op.
  - 2 R: {ovf bit16, full bit9, empty bit8, count bits 4:0}.
  - 3 RW: mask[N_IN-1:0], reset all 1.
  - 4 W: d[0]=1 clears ovf; reads 0. Clear and overflow-set in the same cycle → ovf=1.
  - 5 RW: thr[7:0], reset DEB_DEFAULT.
  - Other addresses: read 0, writes ignored.
- Simultaneous push and pop: both happen, count unchanged. When full, a pop and push in the same cycle succeed with no overflow.
- irq <= !empty (registered; asserts 1 cycle after the first push, deasserts 1 cycle after the last pop).
- Reset (rst=0), all registers: sync FFs 0, q=0, c=0, prescaler 0, FIFO empty, ovf 0, mask all 1, thr=DEB_DEFAULT, irq=0, timestamp 0. Mid-debounce reset discards the pending change. After release, a pin held high reports a rising event after thr ticks.
- spo is combinational; no read side effects except the pop on re at a==1.

Optional Feature:
- GPIO_IN_TIMESTAMP_EN defined: 15-bit free-running counter, incremented on each tick, wraps 0x7FFF→0. Its value at commit is stored in bits30:16 of the event.
- Undefined: bits30:16 always 0; counter not built.

Test Plan:
- PRESCALE=4, thr=2, pin0 0→1 held → q[0]=1 after 2 ticks + sync, about 11 cycles. Reg1 reads 0x80000100. irq=1 one cycle after the push.
- Pin1 glitch high 1 tick, thr=3 → no event, q unchanged, count=0.
- Pins 0 and 2 rise in the same cycle → two events in order: index 0 (0x80000100), then index 2 (0x80000102), on consecutive cycles.
- 9 masked-in changes, DEPTH 8, no reads → count=8, full=1, ovf=1. Write 1 to reg4 → ovf=0. 8 pops return the first 8 events in order, then irq=0.
- mask=0b1110, toggle pin0 → q[0] follows, no event pushed.
- rst=0 for 1 cycle with 3 events queued → empty=1, irq=0, mask=0xF, thr=DEB_DEFAULT. Re-run with GPIO_IN_TIMESTAMP_EN: the first event after reset carries a timestamp equal to the tick count since reset.
